// File: rtl/bcd_time_of_day.sv
// +--------------------------------------------------------------------------+
// | bcd_time_of_day : 24h BCD time-of-day counter, 12/24h view, load, alarm  |
// | Optional alarm comparator enabled by macro BCD_TOD_ALARM_EN. Rev 1.0     |
// +--------------------------------------------------------------------------+
`default_nettype none

module bcd_time_of_day #(
  parameter int          TICK_DIV = 1,
  parameter logic [7:0]  RESET_HH = 8'h12,
  parameter logic [7:0]  RESET_MM = 8'h00,
  parameter logic [7:0]  RESET_SS = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       mode24,
  input  logic       load_valid,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  output logic       load_err,
  input  logic       alarm_set,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  input  logic       alarm_ack,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       alarm_fire,
  output logic       alarm_pending
);

  localparam int             c_PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_PW-1:0] c_TERM = c_PW'(TICK_DIV - 1);

  function automatic logic [7:0] f_bcd_inc(input logic [7:0] v);
    f_bcd_inc = (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic f_bcd_ok(input logic [7:0] v, input logic [7:0] max);
    f_bcd_ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

  logic [7:0]      r_hh, r_mm, r_ss;
  logic [c_PW-1:0] r_pre;
  logic            r_sec_tick, r_day_wrap, r_load_err;

  logic            w_tc, w_load_ok, w_load, w_adv;
  logic            w_s_wrap, w_m_wrap, w_h_wrap;
  logic [7:0]      w_nxt_hh, w_nxt_mm, w_nxt_ss;

  assign w_tc      = ena && (r_pre == c_TERM);
  assign w_load_ok = f_bcd_ok(load_hh, 8'h23) && f_bcd_ok(load_mm, 8'h59) &&
                     f_bcd_ok(load_ss, 8'h59);
  assign w_load    = load_valid && w_load_ok;
  // A legal load on the terminal-count edge swallows that second.
  assign w_adv     = w_tc && !w_load;

  assign w_s_wrap  = (r_ss == 8'h59);
  assign w_m_wrap  = (r_mm == 8'h59);
  assign w_h_wrap  = (r_hh == 8'h23);
  assign w_nxt_ss  = w_s_wrap ? 8'h00 : f_bcd_inc(r_ss);
  assign w_nxt_mm  = w_s_wrap ? (w_m_wrap ? 8'h00 : f_bcd_inc(r_mm)) : r_mm;
  assign w_nxt_hh  = (w_s_wrap && w_m_wrap) ? (w_h_wrap ? 8'h00 : f_bcd_inc(r_hh)) : r_hh;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hh       <= RESET_HH;
      r_mm       <= RESET_MM;
      r_ss       <= RESET_SS;
      r_pre      <= '0;
      r_sec_tick <= 1'b0;
      r_day_wrap <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_sec_tick <= w_adv;
      r_day_wrap <= w_adv && w_s_wrap && w_m_wrap && w_h_wrap;
      r_load_err <= load_valid && !w_load_ok;
      if (w_load) begin
        r_hh  <= load_hh;
        r_mm  <= load_mm;
        r_ss  <= load_ss;
        r_pre <= '0;
      end else if (ena) begin
        r_pre <= w_tc ? '0 : r_pre + c_PW'(1);
        if (w_tc) begin
          r_hh <= w_nxt_hh;
          r_mm <= w_nxt_mm;
          r_ss <= w_nxt_ss;
        end
      end
    end
  end

  // 12-hour view: 13..19 -> 01..07, 20/21 -> 08/09, 22/23 -> 10/11.
  always_comb begin
    hh = r_hh;
    pm = 1'b0;
    if (!mode24) begin
      if (r_hh == 8'h00) begin
        hh = 8'h12;
      end else if (r_hh == 8'h12) begin
        pm = 1'b1;
      end else if (r_hh > 8'h12) begin
        pm = 1'b1;
        if (r_hh[7:4] == 4'd1)
          hh = {4'd0, r_hh[3:0] - 4'd2};
        else if (r_hh[3:0] < 4'd2)
          hh = {4'd0, r_hh[3:0] + 4'd8};
        else
          hh = {4'd1, r_hh[3:0] - 4'd2};
      end
    end
  end

  assign mm       = r_mm;
  assign ss       = r_ss;
  assign sec_tick = r_sec_tick;
  assign day_wrap = r_day_wrap;
  assign load_err = r_load_err;

`ifdef BCD_TOD_ALARM_EN
  logic [7:0] r_al_hh, r_al_mm;
  logic       r_alarm_fire, r_alarm_pending;
  logic       w_match;

  // Only a counted second can hit the alarm; loads never do.
  assign w_match = w_adv && (w_nxt_hh == r_al_hh) && (w_nxt_mm == r_al_mm) &&
                   (w_nxt_ss == 8'h00);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_al_hh         <= 8'h00;
      r_al_mm         <= 8'h00;
      r_alarm_fire    <= 1'b0;
      r_alarm_pending <= 1'b0;
    end else begin
      if (alarm_set && f_bcd_ok(alarm_hh, 8'h23) && f_bcd_ok(alarm_mm, 8'h59)) begin
        r_al_hh <= alarm_hh;
        r_al_mm <= alarm_mm;
      end
      r_alarm_fire <= w_match;
      if (w_match)
        r_alarm_pending <= 1'b1;
      else if (alarm_ack)
        r_alarm_pending <= 1'b0;
    end
  end

  assign alarm_fire    = r_alarm_fire;
  assign alarm_pending = r_alarm_pending;
`else
  logic w_unused;
  assign w_unused      = ^{alarm_set, alarm_hh, alarm_mm, alarm_ack};
  assign alarm_fire    = 1'b0;
  assign alarm_pending = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/bcd_time_of_day.md
# bcd_time_of_day

Parametrised BCD time-of-day counter that keeps time internally in 24-hour BCD and presents it in either 12-hour (with `pm`) or 24-hour format, selectable at run time without disturbing the count. It adds a seconds prescaler driven by `ena`, a validated time-load port, and per-second and day-rollover strobes. An optional alarm comparator is also available. It sits in the display/timekeeping path and is fed by the system tick enable.

## Interface
- `TICK_DIV`, default 1: number of `ena`-qualified `clk` cycles per second advance; legal range ≥1.
- `RESET_HH`, default 8'h12: reset hour, 24-hour BCD (00–23).
- `RESET_MM`, default 8'h00: reset minute, BCD (00–59).
- `RESET_SS`, default 8'h00: reset second, BCD (00–59).
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: reset, synchronous and active-high; dominates every other input.
- `ena` in 1: tick enable; advances the prescaler.
- `mode24` in 1: 1 = 24-hour presentation, 0 = 12-hour presentation.
- `load_valid` in 1: request to load `load_hh:load_mm:load_ss`.
- `load_hh`, `load_mm`, `load_ss` in 8 each: load time, 24-hour BCD.
- `load_err` out 1: one-cycle pulse when a load request is rejected.
- `alarm_set` in 1: capture `alarm_hh:alarm_mm` as the alarm time (24-hour BCD).
- `alarm_hh`, `alarm_mm` in 8 each: alarm time.
- `alarm_ack` in 1: clears `alarm_pending`.
- `hh`, `mm`, `ss` out 8 each: presented time, BCD.
- `pm` out 1: PM indicator.
- `sec_tick` out 1: one-cycle pulse on every second advance.
- `day_wrap` out 1: one-cycle pulse on the 23:59:59 → 00:00:00 advance.
- `alarm_fire` out 1: one-cycle pulse on alarm match.
- `alarm_pending` out 1: level, set on match, held until acknowledged.

## Operation
**Internal state**
- Registers H, M, S (24-hour BCD) and a prescaler P of width clog2(TICK_DIV), minimum 1 bit.

**Prescaler**
- On `ena` with P < TICK_DIV−1: P increments.
- On `ena` with P = TICK_DIV−1: P resets to 0 and the time advances one second.
- With TICK_DIV=1, every `ena` cycle advances the time.

**Second advance (BCD arithmetic)**
- Low nibble 0–9 rolls into the high nibble.
- S 59 → 00 carries into M; M 59 → 00 carries into H.
- H 23 → 00 with carry asserts `day_wrap`.
- No stored nibble ever exceeds 9; S and M never exceed 59, H never exceeds 23.

**Presentation (combinational from H, M, S; `mm`=M, `ss`=S)**
- `mode24`=1: `hh`=H, `pm`=0.
- `mode24`=0:
  - H=00 → `hh`=12, `pm`=0.
  - H=01–11 → `hh`=H, `pm`=0.
  - H=12 → `hh`=12, `pm`=1.
  - H=13–23 → `hh`=H−12 in BCD, `pm`=1.
- Toggling `mode24` changes only the presentation; the count is unaffected.

**Load**
- `load_valid` is checked in the same cycle. A load is legal when every nibble ≤9, `load_hh` ≤ 8'h23, `load_mm` ≤ 8'h59 and `load_ss` ≤ 8'h59.
- Legal: H, M, S take the load values at that edge and P clears to 0.
- Illegal: state unchanged and `load_err` pulses.
- A legal load in the same cycle as a prescaler terminal count wins; that second advance is discarded and `sec_tick`/`day_wrap` stay 0.

**Reset**
- H=RESET_HH, M=RESET_MM, S=RESET_SS, P=0.
- Alarm time register = 00:00, `alarm_pending`=0, all pulse outputs 0.
- With defaults after reset: 12-hour presentation shows 12:00:00 `pm`=1; 24-hour shows 12:00:00 `pm`=0.
- Reset mid-count or mid-load discards all other inputs in that cycle.

## Timing
- Second advance, load and alarm capture are visible on `hh`/`mm`/`ss`/`pm` the cycle after the qualifying edge.
- `sec_tick`, `day_wrap`, `alarm_fire` and `load_err` are registered and high for exactly the one cycle following their causing edge.
- There is no back-pressure; `load_valid` is a single-cycle strobe and holding it high reloads the time every cycle.
- `ena` low freezes P and the time; `ena` is sampled every cycle.

## Configuration
- Macro: `BCD_TOD_ALARM_EN`.
- Defined:
  - `alarm_set` captures the alarm time (illegal values are ignored, with no `load_err`).
  - On a second advance producing H:M:S = alarm_hh:alarm_mm:00, `alarm_fire` pulses and `alarm_pending` sets.
  - `alarm_ack` clears `alarm_pending`; if a new match coincides with `alarm_ack`, the set wins.
  - A load that lands exactly on the alarm time does not fire.
- Undefined:
  - Alarm ports remain in the port list.
  - `alarm_set`, `alarm_hh`, `alarm_mm` and `alarm_ack` are ignored.
  - `alarm_fire` and `alarm_pending` are constant 0; no alarm registers are built.

## Test plan
- Reset with defaults, `mode24`=0, no `ena` → `hh`=8'h12, `mm`=00, `ss`=00, `pm`=1, all pulses 0.
- TICK_DIV=4, load 23:59:58, then `ena` held high for 8 cycles → `sec_tick` pulses every 4th cycle; time reads 23:59:59, then 00:00:00 with `day_wrap`=1 for one cycle; 12-hour view shows 12:00:00 `pm`=0.
- Load 13:05:09 and toggle `mode24` each cycle → `hh` alternates 8'h13/`pm`=0 and 8'h01/`pm`=1; `mm`=05 and `ss`=09 are unchanged.
- Load 8'h24:00:00, then 8'h1A:00:00, then 10:60:00 → `load_err` pulses each time and the time is unchanged.
- Load 10:00:00 in the same cycle as a terminal-count `ena` → time is 10:00:00, `sec_tick`=0, P=0.
- With `BCD_TOD_ALARM_EN` defined: set alarm 07:30, load 07:29:59, apply one tick → `alarm_fire` pulses and `alarm_pending`=1 until `alarm_ack`. Without the macro, the same stimulus leaves both outputs 0.
